toggle_event_receiver: RTL and testbench
========================================

TOGGLE_EVENT_RECEIVER -- requirements
Module: toggle_event_receiver

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on tog_in; legal range 2..4.
REQ-002 SHALL have parameter CNT_W, default 4, width of the pending-event counter.
REQ-003 SHALL have parameter TOT_W, default 16, width of the total-event counter.
REQ-004 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port tog_in  input  1  asynchronous toggle line from the sender's toggle flop; each level change marks one event.
REQ-007 SHALL have port evt_valid  output  1  at least one event is pending delivery.
REQ-008 SHALL have port evt_ready  input  1  consumer accepts one event when high with evt_valid.
REQ-009 SHALL have port ack_tog  output  1  return toggle line that changes level once per accepted event.
REQ-010 SHALL have port pending  output  CNT_W  number of detected, not yet accepted events.
REQ-011 SHALL have port total  output  TOT_W  count of all detected events, including dropped ones.
REQ-012 SHALL have port overflow  output  1  sticky flag: an event was dropped.
REQ-013 SHALL have port clr_ovf  input  1  clears overflow.

Function
REQ-014 SHALL pass tog_in through a SYNC_STAGES-deep flop chain; sync_out is the last stage.
REQ-015 SHALL use a state machine with states PRIME and RUN.
REQ-016 PRIME SHALL last exactly SYNC_STAGES+1 cycles after rst deasserts.
REQ-017 On the last PRIME cycle, the block SHALL load the reference register ref from sync_out, generate no event, and enter RUN.
REQ-018 In RUN, an event SHALL be detected in each cycle where sync_out != ref; ref SHALL then load sync_out in the same edge.
REQ-019 A tog_in change first captured at edge N SHALL raise evt_valid after edge N+SYNC_STAGES, provided pending was 0.
REQ-020 evt_valid SHALL equal (pending != 0).
REQ-021 Acceptance SHALL occur on an edge where evt_valid && evt_ready.
REQ-022 Each acceptance SHALL decrement pending by 1 and invert ack_tog.
REQ-023 evt_ready while evt_valid=0 SHALL have no effect.
REQ-024 Event with no acceptance: if pending < 2^CNT_W-1, pending SHALL increment.
REQ-025 Event with no acceptance at pending = 2^CNT_W-1: pending SHALL hold and overflow SHALL set.
REQ-026 Event and acceptance on the same edge: pending SHALL hold, ack_tog SHALL invert, and overflow SHALL NOT set.
REQ-027 total SHALL increment on every detected event, including dropped ones, and wrap modulo 2^TOT_W.
REQ-028 clr_ovf SHALL clear overflow; if a drop occurs on the same edge, set SHALL win.
REQ-029 In PRIME, events and acceptances SHALL be ignored; evt_valid SHALL be 0.

Reset
REQ-030 While rst=1, the synchronizer chain, ref, pending, total, overflow and ack_tog SHALL be 0, and state SHALL be PRIME with the prime counter cleared.
REQ-031 Reset asserted mid-operation SHALL discard all pending events without toggling ack_tog.
REQ-032 After reset, a tog_in held at 1 SHALL NOT produce an event.

Verification
REQ-033 Bench SHALL cover: rst then tog_in=1 held 20 cycles -> evt_valid=0, total=0 throughout.
REQ-034 Bench SHALL cover: in RUN, tog_in 0->1 captured at edge N, evt_ready=0 -> evt_valid=1 after edge N+2, pending=1, total=1; evt_ready=1 for one cycle -> pending=0, ack_tog 0->1.
REQ-035 Bench SHALL cover: 17 tog_in toggles spaced 4 cycles, evt_ready=0, CNT_W=4 -> pending=15, total=17, overflow=1; clr_ovf pulse -> overflow=0.
REQ-036 Bench SHALL cover: pending=3 with event and acceptance on the same edge -> pending=3, total+1, ack_tog inverts, overflow=0.
REQ-037 Bench SHALL cover: TOT_W=4, 16 events -> total wraps to 0 with correct pending/ack counts.
REQ-038 Bench SHALL cover: rst asserted with pending=5 -> next edge pending=0, evt_valid=0, ack_tog=0, and no event after reset release.

Source files
------------

// File: rtl/toggle_event_receiver.sv
// Toggle-line event receiver: synchronizes a sender's toggle flop, counts level
// changes as events, and hands them to a valid/ready consumer with a return toggle.
module toggle_event_receiver #(
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 4,
   parameter int TOT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             tog_in,
   output logic             evt_valid,
   input  logic             evt_ready,
   output logic             ack_tog,
   output logic [CNT_W-1:0] pending,
   output logic [TOT_W-1:0] total,
   output logic             overflow,
   input  logic             clr_ovf
);

   localparam logic [2:0]       PRIME_LAST = 3'(SYNC_STAGES);
   localparam logic [CNT_W-1:0] PEND_MAX   = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] PEND_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [TOT_W-1:0] TOT_ONE    = {{(TOT_W-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_PRIME = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   state_t                 r_state, w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_sync_out;
   logic [2:0]             r_prime_cnt, w_prime_cnt_nxt;
   logic                   r_ref, w_ref_nxt;
   logic                   w_evt, w_acc, w_drop;
   logic [CNT_W-1:0]       r_pending, w_pending_nxt;
   logic [TOT_W-1:0]       r_total, w_total_nxt;
   logic                   r_overflow, w_overflow_nxt;
   logic                   r_ack_tog, w_ack_tog_nxt;
   logic                   r_evt_valid;

   assign w_sync_out = r_sync[SYNC_STAGES-1];

   // Metastability chain on the asynchronous toggle line.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_sync <= {SYNC_STAGES{1'b0}};
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], tog_in};
      end
   end

   // FSM state, prime counter and reference level.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ST_PRIME;
         r_prime_cnt <= 3'd0;
         r_ref       <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_prime_cnt <= w_prime_cnt_nxt;
         r_ref       <= w_ref_nxt;
      end
   end

   // PRIME waits for the chain to fill, then adopts its level without an event.
   always_comb begin
      w_state_nxt     = r_state;
      w_prime_cnt_nxt = r_prime_cnt;
      w_ref_nxt       = r_ref;
      w_evt           = 1'b0;
      w_acc           = 1'b0;
      case (r_state)
         ST_PRIME: begin
            if (r_prime_cnt == PRIME_LAST) begin
               w_ref_nxt   = w_sync_out;
               w_state_nxt = ST_RUN;
            end else begin
               w_prime_cnt_nxt = r_prime_cnt + 3'd1;
            end
         end
         ST_RUN: begin
            w_evt     = (w_sync_out != r_ref);
            w_ref_nxt = w_sync_out;
            w_acc     = r_evt_valid && evt_ready;
         end
         default: begin
            w_state_nxt     = ST_PRIME;
            w_prime_cnt_nxt = 3'd0;
         end
      endcase
   end

   // Simultaneous event and acceptance cancel, so a full counter never drops then.
   always_comb begin
      w_drop        = 1'b0;
      w_pending_nxt = r_pending;
      w_ack_tog_nxt = r_ack_tog ^ w_acc;
      if (w_evt) begin
         w_total_nxt = r_total + TOT_ONE;
      end else begin
         w_total_nxt = r_total;
      end
      if (w_evt && !w_acc) begin
         if (r_pending == PEND_MAX) begin
            w_drop = 1'b1;
         end else begin
            w_pending_nxt = r_pending + PEND_ONE;
         end
      end else if (w_acc && !w_evt) begin
         w_pending_nxt = r_pending - PEND_ONE;
      end else begin
         w_pending_nxt = r_pending;
      end
      if (w_drop) begin
         w_overflow_nxt = 1'b1;
      end else if (clr_ovf) begin
         w_overflow_nxt = 1'b0;
      end else begin
         w_overflow_nxt = r_overflow;
      end
   end

   // Registered outputs; evt_valid tracks the next pending value.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending   <= {CNT_W{1'b0}};
         r_total     <= {TOT_W{1'b0}};
         r_overflow  <= 1'b0;
         r_ack_tog   <= 1'b0;
         r_evt_valid <= 1'b0;
      end else begin
         r_pending   <= w_pending_nxt;
         r_total     <= w_total_nxt;
         r_overflow  <= w_overflow_nxt;
         r_ack_tog   <= w_ack_tog_nxt;
         r_evt_valid <= (w_pending_nxt != {CNT_W{1'b0}});
      end
   end

   assign evt_valid = r_evt_valid;
   assign ack_tog   = r_ack_tog;
   assign pending   = r_pending;
   assign total     = r_total;
   assign overflow  = r_overflow;

endmodule

// File: tb/tb_toggle_event_receiver.sv
// Bench for toggle_event_receiver: directed scenarios plus random traffic, checked
// every cycle against an event-level model of the toggle protocol.
module tb_toggle_event_receiver;

   localparam int S       = 2;
   localparam int CNT_W   = 4;
   localparam int TOT_W   = 16;
   localparam int TOT_W_S = 4;
   localparam int PMAX    = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic tog_in = 1'b0;
   logic evt_ready = 1'b0;
   logic clr_ovf = 1'b0;

   logic               evt_valid, ack_tog, overflow;
   logic [CNT_W-1:0]   pending;
   logic [TOT_W-1:0]   total;
   logic               evt_valid_w, ack_tog_w, overflow_w;
   logic [CNT_W-1:0]   pending_w;
   logic [TOT_W_S-1:0] total_w;

   int n_checks = 0;
   int n_errors = 0;

   // Model state: pending, total, sticky overflow, ack level, edges since reset,
   // and the last S+1 sampled tog_in levels (d[i] = sample from i+1 edges ago).
   int m_pend, m_tot, m_n;
   bit m_ovf, m_ack;
   bit d[0:S];

   toggle_event_receiver #(.SYNC_STAGES(S), .CNT_W(CNT_W), .TOT_W(TOT_W)) dut (
      .clk(clk), .rst(rst), .tog_in(tog_in), .evt_valid(evt_valid),
      .evt_ready(evt_ready), .ack_tog(ack_tog), .pending(pending),
      .total(total), .overflow(overflow), .clr_ovf(clr_ovf)
   );

   toggle_event_receiver #(.SYNC_STAGES(S), .CNT_W(CNT_W), .TOT_W(TOT_W_S)) dut_w (
      .clk(clk), .rst(rst), .tog_in(tog_in), .evt_valid(evt_valid_w),
      .evt_ready(evt_ready), .ack_tog(ack_tog_w), .pending(pending_w),
      .total(total_w), .overflow(overflow_w), .clr_ovf(clr_ovf)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   // An event is a level change of tog_in seen S edges late; the first S+1
   // edges after reset only settle the reference level.
   task automatic model_edge();
      bit evt, acc, drop;
      if (rst) begin
         m_pend = 0; m_tot = 0; m_ovf = 1'b0; m_ack = 1'b0; m_n = 0;
         for (int i = 0; i <= S; i++) d[i] = 1'b0;
      end else begin
         m_n++;
         evt = 1'b0; acc = 1'b0; drop = 1'b0;
         if (m_n > S + 1) begin
            evt = (d[S-1] != d[S]);
            acc = (m_pend != 0) && evt_ready;
         end
         if (acc) m_ack = !m_ack;
         if (evt) m_tot++;
         if (evt && !acc) begin
            if (m_pend == PMAX) drop = 1'b1;
            else m_pend++;
         end else if (acc && !evt) begin
            m_pend--;
         end
         if (drop) m_ovf = 1'b1;
         else if (clr_ovf) m_ovf = 1'b0;
         for (int i = S; i > 0; i--) d[i] = d[i-1];
         d[0] = tog_in;
      end
   endtask

   task automatic compare_all();
      check_eq("valid",    32'(evt_valid),   32'(m_pend != 0));
      check_eq("pending",  32'(pending),     32'(m_pend));
      check_eq("total",    32'(total),       32'(m_tot % (1 << TOT_W)));
      check_eq("overflow", 32'(overflow),    32'(m_ovf));
      check_eq("ack_tog",  32'(ack_tog),     32'(m_ack));
      check_eq("total_w",  32'(total_w),     32'(m_tot % (1 << TOT_W_S)));
      check_eq("ack_w",    32'(ack_tog_w),   32'(m_ack));
      check_eq("pend_w",   32'(pending_w),   32'(m_pend));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      model_edge();
      compare_all();
   endtask

   task automatic reset_prime(input logic lvl);
      rst = 1'b1; tog_in = lvl; evt_ready = 1'b0; clr_ovf = 1'b0;
      step();
      rst = 1'b0;
      repeat (5) step();
   endtask

   initial begin
      // Reset with tog_in held high: no event ever appears.
      tog_in = 1'b1; rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         check_eq("idle_valid", 32'(evt_valid), 32'd0);
         check_eq("idle_total", 32'(total), 32'd0);
      end

      // Single event latency and acceptance.
      reset_prime(1'b0);
      tog_in = 1'b1;
      step();
      step();
      check_eq("lat_n1_valid", 32'(evt_valid), 32'd0);
      step();
      check_eq("lat_n2_valid", 32'(evt_valid), 32'd1);
      check_eq("lat_pending", 32'(pending), 32'd1);
      check_eq("lat_total", 32'(total), 32'd1);
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      check_eq("acc_pending", 32'(pending), 32'd0);
      check_eq("acc_ack", 32'(ack_tog), 32'd1);

      // Saturation and overflow.
      reset_prime(1'b0);
      for (int i = 0; i < 17; i++) begin
         tog_in = ~tog_in;
         repeat (4) step();
      end
      check_eq("sat_pending", 32'(pending), 32'd15);
      check_eq("sat_total", 32'(total), 32'd17);
      check_eq("sat_ovf", 32'(overflow), 32'd1);
      clr_ovf = 1'b1;
      step();
      clr_ovf = 1'b0;
      check_eq("clr_ovf", 32'(overflow), 32'd0);

      // Event and acceptance on the same edge.
      reset_prime(1'b0);
      for (int i = 0; i < 3; i++) begin
         tog_in = ~tog_in;
         repeat (4) step();
      end
      check_eq("same_pre", 32'(pending), 32'd3);
      tog_in = ~tog_in;
      step();
      step();
      evt_ready = 1'b1;
      step();
      evt_ready = 1'b0;
      check_eq("same_pending", 32'(pending), 32'd3);
      check_eq("same_total", 32'(total), 32'd4);
      check_eq("same_ack", 32'(ack_tog), 32'd1);
      check_eq("same_ovf", 32'(overflow), 32'd0);

      // Total wrap on the narrow instance.
      reset_prime(1'b0);
      for (int i = 0; i < 16; i++) begin
         tog_in = ~tog_in;
         evt_ready = (i % 2 == 0);
         step();
         evt_ready = 1'b0;
         repeat (3) step();
      end
      check_eq("wrap_total_w", 32'(total_w), 32'd0);
      check_eq("wrap_total", 32'(total), 32'd16);

      // Reset mid-operation with pending events.
      reset_prime(1'b0);
      for (int i = 0; i < 5; i++) begin
         tog_in = ~tog_in;
         repeat (4) step();
      end
      check_eq("rst_pre", 32'(pending), 32'd5);
      rst = 1'b1;
      step();
      check_eq("rst_pending", 32'(pending), 32'd0);
      check_eq("rst_valid", 32'(evt_valid), 32'd0);
      check_eq("rst_ack", 32'(ack_tog), 32'd0);
      rst = 1'b0;
      repeat (20) step();
      check_eq("rst_after_total", 32'(total), 32'd0);
      check_eq("rst_after_valid", 32'(evt_valid), 32'd0);

      // Random traffic.
      reset_prime(1'b0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(2, 0) == 0) tog_in = ~tog_in;
         if (i < 1500) evt_ready = ($urandom_range(3, 0) == 0);
         else evt_ready = ($urandom_range(1, 0) == 0);
         clr_ovf = ($urandom_range(49, 0) == 0);
         rst = ($urandom_range(299, 0) == 0);
         step();
      end
      rst = 1'b0; clr_ovf = 1'b0; evt_ready = 1'b0;
      repeat (4) step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
